// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Widest character supported; narrower characters are zero-extended before the XOR.
  localparam int CHAR_MAX_BITS = 9;

  function automatic logic char_parity(input logic [CHAR_MAX_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a registered not-full flag.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         not_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             not_full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok_s = push & not_full_r;
  assign pop_ok_s  = pop & (count_r != CNT_W'(0));

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_s = count_r + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_s = count_r - CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Pointers, count and the registered not-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      count_r    <= CNT_W'(0);
      not_full_r <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_s;
      not_full_r <= (count_s < CNT_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign not_full = not_full_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: word FIFO feeding a per-character serialiser with optional parity.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int WIDTH_SIZE   = 32,
  parameter int CHAR_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid,
  input  logic [WIDTH_SIZE-1:0]             input_tx,
  input  logic                              PF,
  input  logic                              err,
  output logic                              ready,
  output logic                              Tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int NUM_CHARS = WIDTH_SIZE / CHAR_BITS;
  localparam int ENTRY_W   = WIDTH_SIZE + 2;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int CLK_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = $clog2(CHAR_BITS);
  localparam int CHAR_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  localparam logic [CLK_W-1:0]  CLK_RELOAD = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(CHAR_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
  localparam logic [CHAR_W-1:0] LAST_CHAR  = CHAR_W'(NUM_CHARS - 1);
  localparam logic              PAR_ODD    = (PARITY_ODD != 0);

  logic                  push_s;
  logic                  pop_s;
  logic [ENTRY_W-1:0]    entry_s;
  logic [ENTRY_W-1:0]    head_s;
  logic [CNT_W-1:0]      count_s;
  logic                  not_full_s;

  tx_state_e             state_r;
  tx_state_e             state_s;
  logic [CLK_W-1:0]      clk_cnt_r;
  logic [CLK_W-1:0]      clk_cnt_s;
  logic [BIT_W-1:0]      bit_idx_r;
  logic [BIT_W-1:0]      bit_idx_s;
  logic [CHAR_W-1:0]     char_idx_r;
  logic [CHAR_W-1:0]     char_idx_s;
  logic [WIDTH_SIZE-1:0] shift_r;
  logic [WIDTH_SIZE-1:0] shift_s;
  logic                  pf_r;
  logic                  pf_s;
  logic                  err_r;
  logic                  err_s;
  logic                  tx_r;
  logic                  tx_s;
  logic                  busy_r;
  logic                  bit_tick_s;
  logic [CHAR_BITS-1:0]  next_char_s;
  logic                  parity_s;

  assign push_s  = valid & not_full_s;
  assign entry_s = {err, PF, input_tx};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .count     (count_s),
    .not_full  (not_full_s)
  );

  assign bit_tick_s = (clk_cnt_r == CLK_W'(0));

  // Serialiser next-state: bit timing, data/stop indexing and character stepping.
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_idx_s  = bit_idx_r;
    char_idx_s = char_idx_r;
    shift_s    = shift_r;
    pf_s       = pf_r;
    err_s      = err_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_s != CNT_W'(0)) begin
          pop_s      = 1'b1;
          shift_s    = head_s[WIDTH_SIZE-1:0];
          pf_s       = head_s[WIDTH_SIZE];
          err_s      = head_s[WIDTH_SIZE+1];
          char_idx_s = CHAR_W'(0);
          clk_cnt_s  = CLK_RELOAD;
          state_s    = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) begin
          clk_cnt_s = CLK_RELOAD;
          bit_idx_s = BIT_W'(0);
          state_s   = DATA;
        end else begin
          clk_cnt_s = clk_cnt_r - CLK_W'(1);
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          clk_cnt_s = CLK_RELOAD;
          if (bit_idx_r == LAST_DATA) begin
            bit_idx_s = BIT_W'(0);
            state_s   = pf_r ? PARITY : STOP;
          end else begin
            bit_idx_s = bit_idx_r + BIT_W'(1);
          end
        end else begin
          clk_cnt_s = clk_cnt_r - CLK_W'(1);
        end
      end
      PARITY: begin
        if (bit_tick_s) begin
          clk_cnt_s = CLK_RELOAD;
          bit_idx_s = BIT_W'(0);
          state_s   = STOP;
        end else begin
          clk_cnt_s = clk_cnt_r - CLK_W'(1);
        end
      end
      STOP: begin
        if (bit_tick_s) begin
          clk_cnt_s = CLK_RELOAD;
          if (bit_idx_r == LAST_STOP) begin
            bit_idx_s = BIT_W'(0);
            if (char_idx_r == LAST_CHAR) begin
              state_s = IDLE;
            end else begin
              char_idx_s = char_idx_r + CHAR_W'(1);
              shift_s    = shift_r >> CHAR_BITS;
              state_s    = START;
            end
          end else begin
            bit_idx_s = bit_idx_r + BIT_W'(1);
          end
        end else begin
          clk_cnt_s = clk_cnt_r - CLK_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so Tx can be registered.
  always_comb begin
    next_char_s = shift_s[CHAR_BITS-1:0];
    parity_s    = char_parity(CHAR_MAX_BITS'(next_char_s)) ^ PAR_ODD ^ err_s;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = next_char_s[bit_idx_s];
      PARITY:  tx_s = parity_s;
      default: tx_s = 1'b1;
    endcase
  end

  // Serialiser state and registered line outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      clk_cnt_r  <= CLK_W'(0);
      bit_idx_r  <= BIT_W'(0);
      char_idx_r <= CHAR_W'(0);
      shift_r    <= WIDTH_SIZE'(0);
      pf_r       <= 1'b0;
      err_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_idx_r  <= bit_idx_s;
      char_idx_r <= char_idx_s;
      shift_r    <= shift_s;
      pf_r       <= pf_s;
      err_r      <= err_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign Tx         = tx_r;
  assign busy       = busy_r;
  assign ready      = not_full_s;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised bench for uart_tx_buffered against a queue-based line model.
module tb_uart_tx_buffered;

  localparam int W     = 32;
  localparam int CB    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int SB    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_e, valid_o;
  logic [31:0] input_tx;
  logic        pf, err;
  logic        ready_e, tx_e, busy_e;
  logic        ready_o, tx_o, busy_o;
  logic [2:0]  cnt_e, cnt_o;
  logic        sel_odd;
  logic [5:0]  obs_vec;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .WIDTH_SIZE(W), .CHAR_BITS(CB), .FIFO_DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid_e), .input_tx(input_tx), .PF(pf), .err(err),
    .ready(ready_e), .Tx(tx_e), .busy(busy_e), .fifo_count(cnt_e)
  );

  uart_tx_buffered #(
    .WIDTH_SIZE(W), .CHAR_BITS(CB), .FIFO_DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(1)
  ) dut_odd (
    .clk(clk), .reset(reset), .valid(valid_o), .input_tx(input_tx), .PF(pf), .err(err),
    .ready(ready_o), .Tx(tx_o), .busy(busy_o), .fifo_count(cnt_o)
  );

  assign obs_vec = sel_odd ? {tx_o, busy_o, ready_o, cnt_o} : {tx_e, busy_e, ready_e, cnt_e};

  int checks;
  int errors;

  // Model: queued words, the line bit stream of the word on air, and remaining busy cycles.
  logic [31:0] mq_word[$];
  bit          mq_pf[$];
  bit          mq_err[$];
  bit          line_q[$];
  int          busy_rem;
  bit          exp_tx, exp_busy, exp_ready, accepted;
  int          exp_count;

  function automatic logic [5:0] exp_vec();
    return {exp_tx, exp_busy, exp_ready, 3'(exp_count)};
  endfunction

  function automatic void model_reset();
    mq_word.delete(); mq_pf.delete(); mq_err.delete(); line_q.delete();
    busy_rem = 0; exp_tx = 1'b1; exp_busy = 1'b0; exp_ready = 1'b1; exp_count = 0;
    accepted = 1'b0;
  endfunction

  function automatic void frame_bits(input logic [31:0] w, input bit p, input bit e, input bit odd);
    bit seq[$];
    for (int c = 0; c < W / CB; c++) begin
      int ch;
      ch = int'((w >> (CB * c)) & 32'hFF);
      seq.push_back(1'b0);
      for (int b = 0; b < CB; b++) seq.push_back(bit'((ch >> b) & 1));
      if (p) seq.push_back(bit'(($countones(ch) % 2) ^ int'(odd) ^ int'(e)));
      for (int s = 0; s < SB; s++) seq.push_back(1'b1);
    end
    foreach (seq[k]) begin
      for (int r = 0; r < CPB; r++) line_q.push_back(seq[k]);
    end
  endfunction

  task automatic tick();
    logic v;
    @(posedge clk);
    v = sel_odd ? valid_o : valid_e;
    accepted = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      if (busy_rem == 0 && mq_word.size() > 0) begin
        frame_bits(mq_word.pop_front(), mq_pf.pop_front(), mq_err.pop_front(), sel_odd);
        busy_rem = line_q.size();
      end else if (busy_rem > 0) begin
        busy_rem--;
      end
      if (v && exp_ready) begin
        mq_word.push_back(input_tx); mq_pf.push_back(pf); mq_err.push_back(err);
        accepted = 1'b1;
      end
      exp_count = mq_word.size();
      exp_ready = (exp_count < DEPTH);
      exp_busy  = (busy_rem > 0);
      exp_tx    = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 6'b1_0_1_000) begin
      errors++; $display("FAIL reset_async got %b want %b", obs_vec, 6'b101000);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_vec !== 6'b1_0_1_000) begin
        errors++; $display("FAIL reset_hold cyc %0d got %b want %b", i, obs_vec, 6'b101000);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_release cyc %0d got %b want %b", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_plain();
    int busy_cycles;
    busy_cycles = 0;
    sel_odd = 1'b0;
    input_tx = 32'h55555555; pf = 1'b0; err = 1'b0; valid_e = 1'b1;
    tick();
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL plain_accept got %b want %b", obs_vec, exp_vec());
    end
    valid_e = 1'b0;
    input_tx = $urandom; pf = 1'b1; err = 1'b1;
    for (int i = 0; i < 170; i++) begin
      tick();
      if (busy_e) busy_cycles++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL plain_line cyc %0d got %b want %b", i, obs_vec, exp_vec());
      end
    end
    checks++;
    if (busy_cycles !== 160) begin
      errors++; $display("FAIL plain_busy_len got %0d want 160", busy_cycles);
    end
  endtask

  task automatic test_parity(input bit err_v, input logic [3:0] par_exp);
    sel_odd = 1'b0;
    input_tx = 32'h55555D5D; pf = 1'b1; err = err_v; valid_e = 1'b1;
    tick();
    valid_e = 1'b0;
    for (int i = 0; i < 4 * 44 + 4; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL parity_line err=%0d cyc %0d got %b want %b", err_v, i, obs_vec, exp_vec());
      end
      if (i % 44 == 37 && i < 4 * 44) begin
        checks++;
        if (tx_e !== par_exp[i / 44]) begin
          errors++; $display("FAIL parity_bit err=%0d char %0d got %b want %b", err_v, i / 44, tx_e, par_exp[i / 44]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[6];
    bit          pfs[6], errs[6];
    int          idx, budget;
    sel_odd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      words[k] = $urandom; pfs[k] = 1'($urandom_range(0, 1)); errs[k] = 1'($urandom_range(0, 1));
    end
    idx = 0; budget = 0;
    input_tx = words[0]; pf = pfs[0]; err = errs[0]; valid_e = 1'b1;
    while (idx < 6 && budget < 2000) begin
      tick();
      budget++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL b2b_line cyc %0d got %b want %b", budget, obs_vec, exp_vec());
      end
      if (accepted) begin
        if (idx == 4) begin
          checks++;
          if ({ready_e, cnt_e} !== 4'b0_100) begin
            errors++; $display("FAIL b2b_full got rdy/cnt=%b want 0100", {ready_e, cnt_e});
          end
        end
        idx++;
        if (idx < 6) begin
          input_tx = words[idx]; pf = pfs[idx]; err = errs[idx];
        end else begin
          valid_e = 1'b0;
        end
      end
    end
    valid_e = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++; $display("FAIL b2b_accept_timeout got %0d words want 6", idx);
    end
    budget = 0;
    while ((busy_rem > 0 || mq_word.size() > 0 || busy_e) && budget < 2000) begin
      tick();
      budget++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL b2b_drain cyc %0d got %b want %b", budget, obs_vec, exp_vec());
      end
    end
    tick();
    checks++;
    if (obs_vec !== 6'b1_0_1_000) begin
      errors++; $display("FAIL b2b_final_idle got %b want %b", obs_vec, 6'b101000);
    end
  endtask

  task automatic test_reset_mid();
    int n, budget;
    sel_odd = 1'b0;
    n = 0; budget = 0;
    input_tx = $urandom; pf = 1'b0; err = 1'b0; valid_e = 1'b1;
    while (n < 4 && budget < 20) begin
      tick();
      budget++;
      if (accepted) begin
        n++;
        input_tx = $urandom;
      end
    end
    valid_e = 1'b0;
    budget = 0;
    while (line_q.size() != 110 && budget < 400) begin
      tick();
      budget++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_line cyc %0d got %b want %b", budget, obs_vec, exp_vec());
      end
    end
    checks++;
    if (line_q.size() != 110 || mq_word.size() != 3) begin
      errors++; $display("FAIL rmid_setup got line %0d queued %0d want 110 3", line_q.size(), mq_word.size());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 6'b1_0_1_000) begin
      errors++; $display("FAIL rmid_async got %b want %b", obs_vec, 6'b101000);
    end
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_vec !== 6'b1_0_1_000) begin
        errors++; $display("FAIL rmid_idle cyc %0d got %b want %b", i, obs_vec, 6'b101000);
      end
    end
    input_tx = $urandom; pf = 1'b1; err = 1'($urandom_range(0, 1)); valid_e = 1'b1;
    tick();
    valid_e = 1'b0;
    for (int i = 0; i < 4 * 44 + 4; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_after cyc %0d got %b want %b", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_odd();
    sel_odd = 1'b1;
    input_tx = 32'h000000FF; pf = 1'b1; err = 1'b0; valid_o = 1'b1;
    tick();
    valid_o = 1'b0;
    for (int i = 0; i < 4 * 44 + 4; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL odd_line cyc %0d got %b want %b", i, obs_vec, exp_vec());
      end
      if (i % 44 == 37 && i < 4 * 44) begin
        checks++;
        if (tx_o !== 1'b1) begin
          errors++; $display("FAIL odd_parity char %0d got %b want 1", i / 44, tx_o);
        end
      end
    end
    sel_odd = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; valid_e = 1'b0; valid_o = 1'b0;
    input_tx = 32'h0; pf = 1'b0; err = 1'b0; sel_odd = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_plain();
    test_parity(1'b1, 4'b1100);
    test_parity(1'b0, 4'b0011);
    test_back_to_back();
    test_reset_mid();
    test_odd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered, parametrised UART transmit path. It accepts WIDTH_SIZE-bit words over a valid/ready handshake and queues them in a FIFO of FIFO_DEPTH entries. Each word is serialised as WIDTH_SIZE/CHAR_BITS characters, least-significant character first. Each character is framed with a start bit, optional per-word parity (even/odd selectable, with parity-error injection) and 1 or 2 stop bits. The block sits between the bus-side producer and the Tx pin.

## Interface
- WIDTH_SIZE, 32, word width; must be an integer multiple of CHAR_BITS
- CHAR_BITS, 8, data bits per character (5..9)
- FIFO_DEPTH, 4, word entries in the FIFO; power of two, ≥2
- CLKS_PER_BIT, 16, clk cycles per serial bit; ≥2
- STOP_BITS, 1, stop bits per character (1 or 2)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid  in  1  producer offers input_tx/err/PF
- input_tx  in  WIDTH_SIZE  word to transmit
- PF  in  1  parity enable for this word
- err  in  1  invert the parity bit of every character of this word (error injection); ignored when PF=0
- ready  out  1  FIFO can accept a word
- Tx  out  1  serial line, idle high
- busy  out  1  serialiser not in IDLE
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently queued

## Operation
- Reset values (immediate on reset low): Tx=1, ready=1, busy=0, fifo_count=0; FIFO emptied; FSM in IDLE. A frame in progress is abandoned with no partial stop bit.
- Push: a word is accepted on a rising clk edge when valid && ready. {err, PF, input_tx} are stored together. ready = (fifo_count < FIFO_DEPTH).
- Pop: in IDLE with fifo_count>0, the head entry is loaded into the shift register and the character index is cleared.
- Simultaneous push and pop in one cycle leaves fifo_count unchanged. A push while full cannot occur because ready=0.
- FSM states: IDLE → START → DATA → PARITY (only if PF) → STOP → START (next character) or IDLE (after the last character).
- Every bit lasts CLKS_PER_BIT cycles, timed by a bit counter that reloads on each bit boundary. DATA sends CHAR_BITS bits LSB first. STOP lasts STOP_BITS bit periods.
- Parity bit = (^char) ^ PARITY_ODD ^ err.
- Tx = 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- valid/input_tx/PF/err are sampled only at acceptance. Changes at any other time have no effect on queued words.

## Timing
- Tx, ready, busy and fifo_count are registered.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. Tx falls, busy rises and fifo_count returns to 0 at edge N+1.
- Character length = CLKS_PER_BIT·(1+CHAR_BITS+PF+STOP_BITS) cycles. There is no gap between characters of the same word.
- Exactly one IDLE cycle (Tx=1, busy=0) separates consecutive words, including when the FIFO is non-empty.
- ready falls on the edge where fifo_count reaches FIFO_DEPTH. It rises on the edge of the next pop.

## Structure
- Shared package uart_pkg: the tx_state_e enum (IDLE, START, DATA, PARITY, STOP) and a parity function.
- Sub-module sync_fifo (parametrised width and depth, count output). It is instantiated with width WIDTH_SIZE+2. The serialiser FSM lives in the top module.

## Test plan
All scenarios use WIDTH_SIZE=32, CHAR_BITS=8, FIFO_DEPTH=4, CLKS_PER_BIT=4, STOP_BITS=1, PARITY_ODD=0.
- Reset held low 5 cycles → Tx=1, ready=1, busy=0, fifo_count=0 throughout. Reset release → no Tx activity.
- Push 0x55555555 with PF=0 → 4 characters, each with bit sequence 0,1,0,1,0,1,0,1,0,1 and 4 cycles per bit. busy high for 160 cycles, then Tx idles high.
- Push 0x55555D5D with PF=1, err=1 → characters 0x5D,0x5D,0x55,0x55 with parity bits 0,0,1,1. Repeat with err=0 → parity bits 1,1,0,0. Each character is 44 cycles.
- Hold valid high for 6 consecutive words from an idle state → word 1 is popped at once. ready drops after word 5 (fifo_count=4). Word 6 is accepted on the edge after word 1's last stop bit. All 6 words appear on Tx in push order.
- Reset asserted during DATA of character 2 with 3 words queued → Tx=1 and fifo_count=0 immediately. After release the line stays idle and the next push transmits normally.
- Push 0x000000FF with PF=1 and PARITY_ODD=1 → character 0xFF has parity bit 1. Characters 0x00 have parity bit 1.
